// File: rtl/wb_commit_if.sv
// Instruction, load-data and commit signals between the write-back source
// decoder, data memory and the write-back commit unit.
interface wb_commit_if #(
  parameter int XLEN = 32
);
  // Handshakes: a transfer occurs on a rising edge where valid and ready are
  // both high; valid must not depend on ready, and fields stay stable while
  // valid is high without ready. commit_valid is a one-cycle pulse with no
  // back-pressure.
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      wb_sel;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] ext_imm;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rready;
  logic            commit_valid;
  logic            commit_we;
  logic [4:0]      commit_rd;
  logic [XLEN-1:0] commit_data;

  modport master (
    output in_valid, wb_sel, rd, funct3, pc_plus4, alu_result, ext_imm,
    output mem_rvalid, mem_rdata,
    input  in_ready, mem_rready,
    input  commit_valid, commit_we, commit_rd, commit_data
  );

  modport slave (
    input  in_valid, wb_sel, rd, funct3, pc_plus4, alu_result, ext_imm,
    input  mem_rvalid, mem_rdata,
    output in_ready, mem_rready,
    output commit_valid, commit_we, commit_rd, commit_data
  );
endinterface

// File: rtl/wb_commit_unit.sv
// Write-back commit stage owning the integer register file and its two read ports.
// Define WB_RF_BYPASS_EN to forward the committing value to same-cycle reads.
module wb_commit_unit #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  wb_commit_if.slave      bus,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [2:0]      sel_q;
  logic [4:0]      rd_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] val_q;
  logic [XLEN-1:0] regs [NREG];

  logic            accept;
  logic            load_done;
  logic            we;
  logic [XLEN-1:0] operand;

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] word,
                                               input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_ext = {{(XLEN-8){b[7]}}, b};
      3'b001:  load_ext = {{(XLEN-16){h[15]}}, h};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, b};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, h};
      default: load_ext = word;
    endcase
  endfunction

  assign bus.in_ready   = (state == IDLE) && !rst;
  assign bus.mem_rready = (state == WAIT_MEM);
  assign accept         = bus.in_valid && bus.in_ready;
  assign load_done      = (state == WAIT_MEM) && bus.mem_rvalid;
  assign dbg_state      = state;

  // Codes 1xx never write; the latched value is forced to zero for them.
  assign we                = (state == WRITE) && !sel_q[2] && (rd_q != 5'd0);
  assign bus.commit_valid  = (state == WRITE);
  assign bus.commit_we     = we;
  assign bus.commit_rd     = rd_q;
  assign bus.commit_data   = (state == WRITE) ? val_q : '0;

  always_comb begin
    operand = '0;
    case (bus.wb_sel)
      3'b001:  operand = bus.pc_plus4;
      3'b010:  operand = bus.alu_result;
      3'b011:  operand = bus.ext_imm;
      default: operand = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = (bus.wb_sel == 3'b000) ? WAIT_MEM : WRITE;
      WAIT_MEM: if (bus.mem_rvalid) state_next = WRITE;
      WRITE:    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= '0;
      rd_q     <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      val_q    <= '0;
    end else if (accept) begin
      sel_q    <= bus.wb_sel;
      rd_q     <= bus.rd;
      funct3_q <= bus.funct3;
      off_q    <= bus.alu_result[1:0];
      val_q    <= operand;
    end else if (load_done) begin
      val_q    <= load_ext(bus.mem_rdata, funct3_q, off_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[rd_q] <= val_q;
    end
  end

  always_comb begin
    rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
`ifdef WB_RF_BYPASS_EN
    if (we && (rs1_addr == rd_q)) rs1_data = val_q;
    if (we && (rs2_addr == rd_q)) rs2_data = val_q;
`endif
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed write-back/load cases, reset abort, then
// randomized transactions against a register-file reference model.
module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [1:0]  dbg_state;

  wb_commit_if #(.XLEN(32)) bus ();

  wb_commit_unit #(.XLEN(32), .NREG(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_rf [32];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected committed value straight from the select/load-width rules.
  function automatic logic [31:0] ref_value(input logic [2:0] sel, input logic [2:0] f3,
                                            input logic [1:0] off, input logic [31:0] pc4,
                                            input logic [31:0] alu, input logic [31:0] imm,
                                            input logic [31:0] mem);
    logic [31:0] byte_v, half_v;
    int          bsh, hsh;
    bsh    = int'(off) * 8;
    hsh    = off[1] ? 16 : 0;
    byte_v = (mem >> bsh) & 32'h0000_00FF;
    half_v = (mem >> hsh) & 32'h0000_FFFF;
    case (sel)
      3'b001: return pc4;
      3'b010: return alu;
      3'b011: return imm;
      3'b000: begin
        case (f3)
          3'b000:  return (byte_v ^ 32'h80) - 32'h80;
          3'b001:  return (half_v ^ 32'h8000) - 32'h8000;
          3'b100:  return byte_v;
          3'b101:  return half_v;
          default: return mem;
        endcase
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic run_txn(input logic [2:0] sel, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] pc4, input logic [31:0] alu,
                         input logic [31:0] imm, input logic [31:0] mem, input int stall);
    logic [31:0] expv, rd_exp;
    logic        exp_we;
    expv   = ref_value(sel, f3, alu[1:0], pc4, alu, imm, mem);
    exp_we = (sel[2] == 1'b0) && (rd != 5'd0);
    exp_q.push_back(expv);

    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid   = 1'b1;
    bus.wb_sel     = sel;
    bus.rd         = rd;
    bus.funct3     = f3;
    bus.pc_plus4   = pc4;
    bus.alu_result = alu;
    bus.ext_imm    = imm;
    // A stray load response while idle must be ignored.
    bus.mem_rvalid = (sel != 3'b000) ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.mem_rdata  = $urandom;
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.wb_sel     = 3'($urandom);
    bus.rd         = 5'($urandom);
    bus.alu_result = $urandom;
    check("in_ready_busy", bus.in_ready, 0);

    if (sel == 3'b000) begin
      for (int i = 0; i < stall; i++) begin
        check("mem_rready_stall", bus.mem_rready, 1);
        check("no_commit_stall", bus.commit_valid, 0);
        @(negedge clk);
      end
      check("mem_rready", bus.mem_rready, 1);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
    end else begin
      check("mem_rready_nonload", bus.mem_rready, 0);
    end

    check("commit_valid", bus.commit_valid, 1);
    check("commit_we", bus.commit_we, exp_we);
    check("commit_rd", bus.commit_rd, rd);
    check("commit_data", bus.commit_data, exp_q.pop_front());
    rs2_addr = rd;
    #1;
    rd_exp = model_rf[rd];
`ifdef WB_RF_BYPASS_EN
    if (exp_we) rd_exp = expv;
`endif
    check("read_during_write", rs2_data, rd_exp);
    if (exp_we) model_rf[rd] = expv;

    @(negedge clk);
    check("commit_pulse_end", bus.commit_valid, 0);
    rs1_addr = rd;
    #1;
    check("read_after_write", rs1_data, model_rf[rd]);
  endtask

  logic [2:0] f3_tab [8];

  initial begin
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.wb_sel     = 3'b0;
    bus.rd         = 5'd0;
    bus.funct3     = 3'b0;
    bus.pc_plus4   = 32'h0;
    bus.alu_result = 32'h0;
    bus.ext_imm    = 32'h0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    rs1_addr       = 5'd0;
    rs2_addr       = 5'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_rready", bus.mem_rready, 0);
    check("rst_commit_valid", bus.commit_valid, 0);
    check("rst_commit_we", bus.commit_we, 0);
    check("rst_commit_rd", bus.commit_rd, 0);
    check("rst_commit_data", bus.commit_data, 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", bus.in_ready, 1);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      check("rst_rf_rs1", rs1_data, 0);
      check("rst_rf_rs2", rs2_data, 0);
    end

    // Directed cases
    run_txn(3'b010, 5'd5, 3'b000, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 0);
    run_txn(3'b000, 5'd7, 3'b000, 32'h0, 32'h0000_0002, 32'h0, 32'h0080_0000, 3);
    run_txn(3'b000, 5'd7, 3'b100, 32'h0, 32'h0000_0002, 32'h0, 32'h0080_0000, 3);
    run_txn(3'b000, 5'd8, 3'b001, 32'h0, 32'h0000_0002, 32'h0, 32'h8001_0000, 1);
    run_txn(3'b000, 5'd9, 3'b101, 32'h0, 32'h0000_0003, 32'h0, 32'h8001_0000, 0);
    run_txn(3'b000, 5'd10, 3'b010, 32'h0, 32'h0000_0002, 32'h0, 32'h8001_0000, 2);
    run_txn(3'b011, 5'd11, 3'b000, 32'h0, 32'h0, 32'hFFFF_F800, 32'h0, 0);
    run_txn(3'b001, 5'd0, 3'b000, 32'h8000_0004, 32'h0, 32'h0, 32'h0, 0);
    run_txn(3'b111, 5'd5, 3'b000, 32'hAAAA_AAAA, 32'h5555_5555, 32'h1, 32'h0, 0);
    run_txn(3'b010, 5'd5, 3'b000, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h0, 0);

    // Reset while a load to x5 waits for memory
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.wb_sel     = 3'b000;
    bus.rd         = 5'd5;
    bus.funct3     = 3'b010;
    bus.alu_result = 32'h0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("abort_wait_mem", bus.mem_rready, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_mem_rready", bus.mem_rready, 0);
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    @(negedge clk);
    rst            = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_2222;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("abort_no_commit", bus.commit_valid, 0);
    check("abort_in_ready_back", bus.in_ready, 1);
    @(negedge clk);
    check("abort_no_commit2", bus.commit_valid, 0);
    rs1_addr = 5'd5;
    #1;
    check("abort_reg_unchanged", rs1_data, model_rf[5]);

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      run_txn(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
              f3_tab[$urandom_range(0, 7)], $urandom, $urandom, $urandom, $urandom,
              $urandom_range(0, 4));
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = 5'($urandom_range(0, 31));
      #1;
      check("rand_rs1", rs1_data, model_rf[rs1_addr]);
      check("rand_rs2", rs2_data, model_rf[rs2_addr]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
Write-back stage directly downstream of the write-back source decoder. Consumes the 3-bit write-back select code and its candidate operands (pc+4, ALU result, extended immediate, load data), waits for load data from data memory, then commits one 32-bit result into the 32x32 integer register file it owns. It also provides the two combinational register read ports used by decode.

Parameters:
XLEN, 32, datapath width
NREG, 32, register count (x0 hardwired zero)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  instruction presented for write-back
in_ready  out  1  unit can accept an instruction
wb_sel  in  3  001 pc+4, 010 ALU, 011 ext imm, 000 memory, other values mean no write
rd  in  5  destination register
funct3  in  3  load width/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
pc_plus4  in  XLEN  candidate for sel 001
alu_result  in  XLEN  candidate for sel 010; bits [1:0] are the load byte offset
ext_imm  in  XLEN  candidate for sel 011
mem_rvalid  in  1  load data valid
mem_rdata  in  XLEN  aligned load word
mem_rready  out  1  unit waiting for load data
rs1_addr, rs2_addr  in  5 each  read addresses
rs1_data, rs2_data  out  XLEN each  combinational read data
commit_valid  out  1  one-cycle commit pulse
commit_we  out  1  register file written this commit
commit_rd  out  5  committed destination
commit_data  out  XLEN  committed value

Behaviour:
- Reset (async, rst high): state IDLE; all 32 registers, latched fields, commit_* = 0; in_ready = 0 while rst is high; mem_rready = 0.
- States: IDLE, WAIT_MEM, WRITE.
- in_ready = (state==IDLE) and not rst. mem_rready = (state==WAIT_MEM).
- IDLE: on in_valid&&in_ready, latch wb_sel, rd, funct3, alu_result[1:0], and the selected operand. sel 000 -> WAIT_MEM; otherwise -> WRITE.
- WAIT_MEM: hold indefinitely until mem_rvalid; on mem_rvalid, latch extended load data and go to WRITE. mem_rvalid outside WAIT_MEM is ignored.
- Load extension: lb/lbu select byte alu_result[1:0]; lh/lhu select halfword alu_result[1] (bit 0 ignored); lw uses the full word; funct3 011/110/111 use the full word. lb/lh sign-extend; lbu/lhu zero-extend.
- WRITE (exactly one cycle): commit_valid=1, commit_rd=rd, commit_data=latched value, commit_we = (sel in {000,001,010,011}) and rd!=0. The register is written at the closing edge when commit_we=1. Next state is IDLE.
- Non-load latency: accepted at edge N, WRITE during cycle N+1, register visible to reads from cycle N+2. Throughput is one instruction per 2 cycles.
- Load latency: 2 + (cycles until mem_rvalid) cycles.
- Reads: rs*_addr==0 gives 0. A read of a register during the WRITE cycle that targets it returns the old value (see optional feature).
- Undefined sel (100,101,110,111): commit_valid pulses with commit_we=0 and commit_data=0.
- Reset mid-operation: any pending load or commit is dropped, no register is written, and a late mem_rvalid is ignored.
- x0 is never written; reading x0 always gives 0.

Optional Feature:
WB_RF_BYPASS_EN. When defined, in WRITE with commit_we=1, a read port whose address equals commit_rd returns commit_data combinationally. When undefined, that read returns the old register value.

Test Plan:
- Reset, then read all 32 registers -> every value 0; in_ready=1 the cycle after rst falls.
- sel=010, rd=5, alu_result=0x1234_5678 -> commit_valid for one cycle with we=1; rs1_addr=5 reads 0x1234_5678 from cycle N+2.
- Load with sel=000, funct3=000, offset 2, rd=7; mem_rvalid after 3 stall cycles with mem_rdata=0x0080_0000 -> x7=0xFFFF_FF80, commit 5 cycles after accept. Same load with funct3=100 -> 0x0000_0080.
- lh at offset 2 with mem_rdata=0x8001_0000 -> 0xFFFF_8001; lhu -> 0x0000_8001; lw -> 0x8001_0000.
- sel=001, rd=0, pc_plus4=0x8000_0004 -> commit_valid=1, we=0, x0 still 0. sel=111 -> no write.
- Assert rst during WAIT_MEM, then pulse mem_rvalid -> no commit and the target register is unchanged. Read during WRITE of the same rd: with the macro defined the read gives the new value; without it, the old value.
